// File: rtl/multdiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package multdiv_pkg;
  localparam int DEF_WIDTH = 32;
  localparam logic [DEF_WIDTH-1:0] INT_MIN = {1'b1, {(DEF_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, DONE} stateE;
  typedef enum logic {OP_MULT, OP_DIV} opE;
endpackage

// File: rtl/multdiv_datapath.sv
// Magnitude shift-add multiplier / restoring divider, one step per cycle, with sign fix-up.
module multdiv_datapath
  import multdiv_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             load,
  input  logic             stepEn,
  input  logic             opSel,
  input  logic [WIDTH-1:0] operandA,
  input  logic [WIDTH-1:0] operandB,
  input  logic [CNT_W-1:0] count,
  output logic             doneCount,
  output logic [WIDTH-1:0] result,
  output logic             exception
);

  // acc is the product high word or the WIDTH+1-bit partial remainder; sreg is the product
  // low word / multiplier, or the dividend being shifted out as quotient bits shift in.
  logic [WIDTH:0]     acc;
  logic [WIDTH-1:0]   sreg;
  logic [WIDTH-1:0]   magB;
  opE                 opReg;
  logic               negRes;
  logic               divZero;

  logic [WIDTH-1:0]   inMagA;
  logic [WIDTH-1:0]   inMagB;
  logic [WIDTH:0]     mulSum;
  logic [WIDTH:0]     divShift;
  logic [WIDTH+1:0]   divDiff;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quot;

  function automatic logic [2*WIDTH-1:0] applySign(input logic [2*WIDTH-1:0] mag, input logic neg);
    return neg ? (~mag + 1'b1) : mag;
  endfunction

  assign inMagA    = operandA[WIDTH-1] ? (~operandA + 1'b1) : operandA;
  assign inMagB    = operandB[WIDTH-1] ? (~operandB + 1'b1) : operandB;
  assign doneCount = (count == CNT_W'(WIDTH));

  assign mulSum   = {1'b0, acc[WIDTH-1:0]} + (sreg[0] ? {1'b0, magB} : {(WIDTH+1){1'b0}});
  assign divShift = {acc[WIDTH-1:0], sreg[WIDTH-1]};
  assign divDiff  = {1'b0, divShift} - {2'b00, magB};

  always_ff @(posedge clock) begin
    if (load) begin
      acc     <= '0;
      sreg    <= inMagA;
      magB    <= inMagB;
      opReg   <= opE'(opSel);
      negRes  <= operandA[WIDTH-1] ^ operandB[WIDTH-1];
      divZero <= (operandB == '0);
    end else if (stepEn) begin
      if (opReg == OP_MULT) begin
        acc  <= {1'b0, mulSum[WIDTH:1]};
        sreg <= {mulSum[0], sreg[WIDTH-1:1]};
      end else if (!divDiff[WIDTH+1]) begin
        acc  <= divDiff[WIDTH:0];
        sreg <= {sreg[WIDTH-2:0], 1'b1};
      end else begin
        acc  <= divShift;
        sreg <= {sreg[WIDTH-2:0], 1'b0};
      end
    end
  end

  assign prod = applySign({acc[WIDTH-1:0], sreg}, negRes);
  assign quot = negRes ? (~sreg + 1'b1) : sreg;

  // A positive quotient with the top bit set can only be INT_MIN / -1.
  always_comb begin
    result    = '0;
    exception = 1'b0;
    if (opReg == OP_MULT) begin
      result    = prod[WIDTH-1:0];
      exception = (prod[2*WIDTH-1:WIDTH] != {WIDTH{prod[WIDTH-1]}});
    end else if (divZero) begin
      result    = '0;
      exception = 1'b1;
    end else begin
      result    = quot;
      exception = !negRes && sreg[WIDTH-1];
    end
  end

endmodule

// File: rtl/multdiv_unit.sv
// Iterative signed multiply/divide unit: control FSM, iteration counter and result registers.
module multdiv_unit
  import multdiv_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             ctrl_reset_n,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  stateE            state;
  stateE            nextState;
  logic [CNT_W-1:0] counter;
  logic             startAny;
  logic             doneCount;
  logic             stepEn;
  logic             finish;
  logic [WIDTH-1:0] dpResult;
  logic             dpException;

  assign startAny = ctrl_MULT | ctrl_DIV;
  assign stepEn   = (state == RUN) && !startAny && !doneCount;
  assign finish   = (state == RUN) && !startAny && doneCount;
  assign busy     = (state != IDLE);

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (startAny) nextState = RUN;
      RUN:     if (startAny) nextState = RUN;
               else if (doneCount) nextState = DONE;
      DONE:    nextState = startAny ? RUN : IDLE;
      default: nextState = IDLE;
    endcase
  end

  // A start in any state reloads the datapath, so an aborted operation never finishes.
  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      state          <= IDLE;
      counter        <= '0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
    end else begin
      state          <= nextState;
      data_resultRDY <= finish;
      if (startAny || (state != RUN)) counter <= '0;
      else if (stepEn) counter <= counter + CNT_W'(1);
      if (finish) begin
        data_result    <= dpResult;
        data_exception <= dpException;
      end
    end
  end

  multdiv_datapath #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) u_datapath (
    .clock     (clock),
    .load      (startAny),
    .stepEn    (stepEn),
    .opSel     (!ctrl_MULT),
    .operandA  (data_operandA),
    .operandB  (data_operandB),
    .count     (counter),
    .doneCount (doneCount),
    .result    (dpResult),
    .exception (dpException)
  );

endmodule

// File: tb/tb_multdiv_unit.sv
// Directed and random checks of multdiv_unit against an arithmetic reference model.
module tb_multdiv_unit;
  logic        clock = 1'b0;
  logic        ctrl_reset_n = 1'b0;
  logic        ctrl_MULT = 1'b0;
  logic        ctrl_DIV = 1'b0;
  logic [31:0] data_operandA = '0;
  logic [31:0] data_operandB = '0;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  int total = 0;
  int bad   = 0;

  multdiv_unit dut (
    .clock          (clock),
    .ctrl_reset_n   (ctrl_reset_n),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void model(input bit isMul, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic e);
    longint p;
    if (isMul) begin
      p = longint'($signed(a)) * longint'($signed(b));
      r = p[31:0];
      e = (p != longint'($signed(r)));
    end else if (b == 32'd0) begin
      r = 32'd0;
      e = 1'b1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      r = 32'h8000_0000;
      e = 1'b1;
    end else begin
      p = longint'($signed(a)) / longint'($signed(b));
      r = p[31:0];
      e = 1'b0;
    end
  endfunction

  task automatic runOp(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b,
                       input string tag);
    logic [31:0] expR;
    logic        expE;
    int          lat;
    model(m, a, b, expR, expE);
    @(negedge clock);
    ctrl_MULT = m; ctrl_DIV = d; data_operandA = a; data_operandB = b;
    @(posedge clock); #1;
    ctrl_MULT = 0; ctrl_DIV = 0; data_operandA = $urandom; data_operandB = $urandom;
    check({tag, ".busy_start"}, 32'(busy), 32'd1);
    lat = 0;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clock); #1;
      if (data_resultRDY) begin lat = n; break; end
    end
    check({tag, ".latency"}, lat, 33);
    check({tag, ".result"}, data_result, expR);
    check({tag, ".exception"}, 32'(data_exception), 32'(expE));
    check({tag, ".busy_rdy"}, 32'(busy), 32'd1);
    @(posedge clock); #1;
    check({tag, ".rdy_pulse"}, 32'(data_resultRDY), 32'd0);
    check({tag, ".busy_after"}, 32'(busy), 32'd0);
    check({tag, ".result_hold"}, data_result, expR);
  endtask

  initial begin
    int rdyCount;
    int firstRdy;
    logic [31:0] a, b;
    bit isMul;

    #12;
    check("reset.result", data_result, 32'd0);
    check("reset.rdy", 32'(data_resultRDY), 32'd0);
    check("reset.busy", 32'(busy), 32'd0);
    check("reset.exc", 32'(data_exception), 32'd0);
    @(negedge clock);
    ctrl_reset_n = 1'b1;

    runOp(1, 0, 32'd7, 32'hFFFF_FFFA, "mul_7x-6");
    runOp(1, 0, 32'h0001_0000, 32'h0001_0000, "mul_ovf");
    runOp(1, 0, 32'h8000_0000, 32'd1, "mul_intmin");
    runOp(0, 1, 32'hFFFF_FFF9, 32'd2, "div_-7/2");
    runOp(0, 1, 32'd100, 32'd0, "div_zero");
    runOp(0, 1, 32'h8000_0000, 32'hFFFF_FFFF, "div_intmin_m1");
    runOp(0, 1, 32'h8000_0000, 32'd2, "div_intmin_2");
    runOp(1, 1, 32'd5, 32'd3, "both_high");

    // Restart mid-operation: only the second operation may signal.
    @(negedge clock);
    ctrl_MULT = 1; data_operandA = 32'd3; data_operandB = 32'd4;
    @(posedge clock); #1;
    ctrl_MULT = 0;
    rdyCount = 0; firstRdy = 0;
    for (int n = 1; n <= 55; n++) begin
      if (n == 10) begin
        @(negedge clock);
        ctrl_DIV = 1; data_operandA = 32'd20; data_operandB = 32'd5;
      end
      @(posedge clock); #1;
      ctrl_DIV = 0;
      if (data_resultRDY) begin
        rdyCount++;
        if (firstRdy == 0) firstRdy = n;
      end
    end
    check("abort.rdy_count", rdyCount, 1);
    check("abort.rdy_edge", firstRdy, 43);
    check("abort.result", data_result, 32'd4);

    // Asynchronous reset partway through an operation.
    @(negedge clock);
    ctrl_MULT = 1; data_operandA = 32'd1234; data_operandB = 32'd5678;
    @(posedge clock); #1;
    ctrl_MULT = 0;
    repeat (15) @(posedge clock);
    #2;
    ctrl_reset_n = 1'b0;
    #1;
    check("areset.result", data_result, 32'd0);
    check("areset.busy", 32'(busy), 32'd0);
    check("areset.rdy", 32'(data_resultRDY), 32'd0);
    @(negedge clock);
    ctrl_reset_n = 1'b1;
    rdyCount = 0;
    for (int n = 0; n < 50; n++) begin
      @(posedge clock); #1;
      if (data_resultRDY) rdyCount++;
    end
    check("areset.no_rdy", rdyCount, 0);
    runOp(0, 1, 32'd1000, 32'hFFFF_FFF9, "after_reset");

    for (int i = 0; i < 24; i++) begin
      isMul = $urandom_range(0, 1) == 1;
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: a = 32'h8000_0000;
        1: b = 32'($signed(32'($urandom_range(0, 20))) - 10);
        2: begin a = a >>> 16; b = b >>> 15; end
        default: ;
      endcase
      runOp(isMul, !isMul, a, b, isMul ? "rand_mul" : "rand_div");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
